// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the core pipeline and the multiply/divide unit.
// The core drives requests and MTHI/MTLO writes; the unit returns status and HI/LO.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        cancel;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_data, rt_data, cancel, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, cancel, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Every operation runs 32 steps on magnitudes; signs are fixed up on the final step.
module muldiv_unit (
   input  logic           clk,
   input  logic           reset,
   muldiv_unit_if.slave   bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_reg;
   logic [5:0]  count_reg;
   logic        div_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic        div_zero_reg;
   logic [31:0] m_reg;
   logic [31:0] q_reg;
   logic [31:0] rs_raw_reg;
   logic [63:0] acc_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic        busy_reg;
   logic        done_reg;

   logic        signed_op;
   logic [31:0] rs_abs;
   logic [31:0] rt_abs;

   always_comb begin
      signed_op = ~bus.op[0];
      rs_abs    = (signed_op && bus.rs_data[31]) ? (~bus.rs_data + 32'd1) : bus.rs_data;
      rt_abs    = (signed_op && bus.rt_data[31]) ? (~bus.rt_data + 32'd1) : bus.rt_data;
   end

   // One iteration. Multiply: m_reg is the multiplicand, q_reg shifts the
   // multiplier out LSB-first. Divide: m_reg is the divisor, q_reg shifts the
   // dividend out MSB-first and collects quotient bits at the bottom.
   logic [32:0] mul_sum;
   logic [32:0] rem_sh;
   logic [31:0] rem_diff;
   logic        rem_fits;
   logic [63:0] acc_next;
   logic [31:0] q_next;

   always_comb begin
      mul_sum  = {1'b0, acc_reg[63:32]} + (q_reg[0] ? {1'b0, m_reg} : 33'd0);
      rem_sh   = {acc_reg[63:32], q_reg[31]};
      rem_fits = (rem_sh >= {1'b0, m_reg});
      rem_diff = rem_sh[31:0] - m_reg;
      acc_next = {mul_sum, acc_reg[31:1]};
      q_next   = {1'b0, q_reg[31:1]};
      if (div_reg) begin
         if (rem_fits) begin
            acc_next = {rem_diff, 32'd0};
            q_next   = {q_reg[30:0], 1'b1};
         end else begin
            acc_next = {rem_sh[31:0], 32'd0};
            q_next   = {q_reg[30:0], 1'b0};
         end
      end
   end

   // Sign fix-up of the completed magnitude result.
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   always_comb begin
      prod_fix = neg_q_reg ? (~acc_next + 64'd1) : acc_next;
      quot_fix = neg_q_reg ? (~q_next + 32'd1) : q_next;
      rem_fix  = neg_r_reg ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
      res_hi   = prod_fix[63:32];
      res_lo   = prod_fix[31:0];
      if (div_reg) begin
         if (div_zero_reg) begin
            res_hi = rs_raw_reg;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= 6'd0;
         div_reg      <= 1'b0;
         neg_q_reg    <= 1'b0;
         neg_r_reg    <= 1'b0;
         div_zero_reg <= 1'b0;
         m_reg        <= 32'd0;
         q_reg        <= 32'd0;
         rs_raw_reg   <= 32'd0;
         acc_reg      <= 64'd0;
         hi_reg       <= 32'd0;
         lo_reg       <= 32'd0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start) begin
                  state_reg    <= RUN;
                  busy_reg     <= 1'b1;
                  count_reg    <= 6'd0;
                  div_reg      <= bus.op[1];
                  neg_q_reg    <= signed_op & (bus.rs_data[31] ^ bus.rt_data[31]);
                  neg_r_reg    <= signed_op & bus.rs_data[31];
                  div_zero_reg <= (bus.rt_data == 32'd0);
                  rs_raw_reg   <= bus.rs_data;
                  acc_reg      <= 64'd0;
                  m_reg        <= bus.op[1] ? rt_abs : rs_abs;
                  q_reg        <= bus.op[1] ? rs_abs : rt_abs;
               end else begin
                  if (bus.hi_we) hi_reg <= bus.wdata;
                  if (bus.lo_we) lo_reg <= bus.wdata;
               end
            end
            RUN: begin
               // Cancel beats the final step: nothing is committed.
               if (bus.cancel) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b0;
               end else begin
                  acc_reg <= acc_next;
                  q_reg   <= q_next;
                  if (count_reg == 6'd31) begin
                     hi_reg    <= res_hi;
                     lo_reg    <= res_lo;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else begin
                     count_reg <= count_reg + 6'd1;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;

endmodule
